// File: rtl/srl_ctrl_pkg.sv
// Shared types and helpers for the SRL delay controller.
package srl_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    RUN
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/srl_delay_line.sv
// Reset-free shift store with a random-access tap, shaped for SRL primitive inference.
module srl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 130,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] q
);

  localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (ce) begin
      stage_d[0] = d;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  always_comb begin
    q = '0;
    if (addr < DEPTH_L) begin
      q = stage_q[addr];
    end
  end

endmodule

// File: rtl/srl_delay_ctrl.sv
// Programmable-length delay line controller: fill tracking, length load, flush.
// Define SRL_DELAY_CTRL_LEVEL_EN to expose the fill count on port level.
module srl_delay_ctrl
  import srl_ctrl_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 130,
  parameter int LW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    len,
  input  logic             len_we,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             cfg_err
`ifdef SRL_DELAY_CTRL_LEVEL_EN
  ,
  output logic [LW-1:0]    level
`endif
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_e          state_q, state_d;
  logic [LW-1:0]   fill_q, fill_d;
  logic [LW-1:0]   len_q, len_d;
  logic            out_valid_q, out_valid_d;
  logic            cfg_err_q, cfg_err_d;
  logic            accept;
  logic            len_ok;
  logic [LW-1:0]   tap_addr;

  assign accept   = in_valid & ~r;
  assign len_ok   = (len != '0) && (len <= DEPTH_L);
  assign tap_addr = len_q - LW'(1);

  // Flush clears the count before the same-cycle accept is counted, so a
  // coincident sample leaves fill at 1.
  always_comb begin
    fill_d = fill_q;
    if (flush) begin
      fill_d = '0;
    end
    if (in_valid && (fill_d < DEPTH_L)) begin
      fill_d = fill_d + LW'(1);
    end

    len_d     = (len_we && len_ok) ? len : len_q;
    cfg_err_d = len_we && !len_ok;

    if (fill_d == '0) begin
      state_d = EMPTY;
    end else if (fill_d >= len_d) begin
      state_d = RUN;
    end else begin
      state_d = FILL;
    end
    out_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q     <= EMPTY;
      fill_q      <= '0;
      len_q       <= DEPTH_L;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  srl_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (LW)
  ) u_line (
    .clk  (clk),
    .ce   (accept),
    .d    (in_data),
    .addr (tap_addr),
    .q    (out_data)
  );

  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;

`ifdef SRL_DELAY_CTRL_LEVEL_EN
  assign level = fill_q;
`endif

endmodule

// File: doc/srl_delay_ctrl.md
SRL_DELAY_CTRL -- requirements
Module: srl_delay_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 130: number of storage stages.
REQ-003 SHALL have parameter LW, default 8: length/level field width, equal to clog2(DEPTH+1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port r, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: accept the sample on in_data this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: sample data.
REQ-008 SHALL have port len, input, LW bits: requested delay, in accepted samples.
REQ-009 SHALL have port len_we, input, 1 bit: load len this cycle.
REQ-010 SHALL have port flush, input, 1 bit: invalidate all stored samples.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds a valid delayed sample.
REQ-012 SHALL have port out_data, output, WIDTH bits: delayed sample.
REQ-013 SHALL have port cfg_err, output, 1 bit: one-cycle pulse flagging a rejected len.

Function
REQ-014 SHALL keep a DEPTH-stage shift store; on an accepted sample, stage0 takes in_data and stage[k] takes stage[k-1]; no shift otherwise.
REQ-015 SHALL drive out_data combinationally from stage[len_q-1]; the stage-select path SHALL NOT depend on r.
REQ-016 SHALL keep a fill counter of 0..DEPTH: +1 per accepted sample, saturating at DEPTH.
REQ-017 SHALL hold out_valid = 1 exactly when fill >= len_q, in state RUN.
REQ-018 SHALL use FSM states EMPTY (fill = 0), FILL (0 < fill < len_q) and RUN (fill >= len_q).
REQ-019 SHALL, when len_we is high and 1 <= len <= DEPTH:
 - load len_q;
 - keep fill unchanged;
 - re-evaluate the state next cycle (RUN->FILL when fill < the new len_q).
REQ-020 SHALL, when len_we is high and len = 0 or len > DEPTH:
 - leave len_q unchanged;
 - pulse cfg_err for one cycle.
REQ-021 SHALL, on flush:
 - clear fill to 0, go to EMPTY and drop out_valid next cycle;
 - not clear the storage;
 - if in_valid is also high, accept the sample and set fill to 1.
REQ-022 SHALL apply in_valid together with len_we as: shift and count first, then compare fill against the new len_q.
REQ-023 SHALL, when flush, len_we and in_valid coincide, apply flush then in_valid; len_we still updates len_q.
REQ-024 SHALL add no latency beyond storage: a sample accepted at edge n appears at out_data after exactly len_q-1 further accepts.

Reset
REQ-025 SHALL, on r high at a clk edge, set fill = 0, state = EMPTY, len_q = DEPTH, out_valid = 0 and cfg_err = 0.
REQ-026 SHALL NOT reset the storage stages, so that they remain inferable as shift-register primitives.
REQ-027 SHALL let r override flush, len_we and in_valid in the same cycle; a mid-stream reset discards fill and length.

Configuration
REQ-028 SHALL, with macro SRL_DELAY_CTRL_LEVEL_EN defined, add output port level (LW bits) equal to fill, reset value 0.
REQ-029 SHALL, with SRL_DELAY_CTRL_LEVEL_EN undefined, have no level port, and all other behaviour SHALL be identical.

Structure
REQ-030 SHALL declare in package srl_ctrl_pkg:
 - the FSM state enum (EMPTY, FILL, RUN);
 - constant function clog2 for LW derivation.
REQ-031 SHALL place storage in sub-module srl_delay_line:
 - ports: clk, ce, d, addr, q;
 - no reset;
 - one instance, with the controller holding fill, len_q, FSM and cfg_err.

Verification
REQ-032 SHALL cover: reset, len_we with len=4, accept 1,2,3,4 -> out_valid rises after the 4th accept with out_data=1; the 5th accept gives out_data=2.
REQ-033 SHALL cover: in RUN with len_q=4 and fill=6, len_we len=8 -> out_valid=0 next cycle; it returns after 2 more accepts (fill=8).
REQ-034 SHALL cover: len_we len=0, then len=131 (DEPTH=130) -> cfg_err pulses once each; len_q and out_valid unchanged.
REQ-035 SHALL cover: flush together with in_valid (data=9) in RUN -> fill=1, state FILL, out_valid=0; with len_q=1, out_valid=1 and out_data=9 next cycle.
REQ-036 SHALL cover: 200 accepts with len_q=130 -> fill saturates at 130, out_data lags input by exactly 129 accepts; r pulse -> fill=0 and out_valid=0 next cycle.
REQ-037 SHALL cover: in_valid gaps (idle cycles between accepts) -> out_data and out_valid unchanged while idle.
